// File: rtl/ex_mem_reg_pkg.sv
// Shared pipeline defines: bus widths, reset/enable levels, NOP encodings and stall-vector indices.
package ex_mem_reg_pkg;

  localparam int REG_BUS_W   = 32;
  localparam int RADDR_BUS_W = 5;
  localparam int ALUOP_BUS_W = 8;
  localparam int STALL_BUS_W = 6;

  localparam logic                   RST_ENABLE    = 1'b1;
  localparam logic                   WRITE_DISABLE = 1'b0;
  localparam logic                   WRITE_ENABLE  = 1'b1;
  localparam logic [REG_BUS_W-1:0]   ZERO_WORD     = '0;
  localparam logic [RADDR_BUS_W-1:0] NOP_REG_ADDR  = '0;
  localparam logic [ALUOP_BUS_W-1:0] EXE_NOP_OP    = 8'b0000_0000;
  localparam logic [ALUOP_BUS_W-1:0] EXE_LW_OP     = 8'b1110_0011;

  // Stall vector bit positions: [0]pc [1]if [2]id [3]ex [4]mem [5]wb
  localparam int STALL_EX  = 3;
  localparam int STALL_MEM = 4;

endpackage

// File: rtl/ex_mem_reg.sv
// EX->MEM pipeline register with stall hold, bubble insertion, flush, and the
// madd/msub partial-product feedback path back into EX.
module ex_mem_reg
  import ex_mem_reg_pkg::*;
#(
  parameter int REG_W   = REG_BUS_W,
  parameter int RADDR_W = RADDR_BUS_W,
  parameter int ALUOP_W = ALUOP_BUS_W,
  parameter int STALL_W = STALL_BUS_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [RADDR_W-1:0] ex_wd,
  input  logic               ex_wreg,
  input  logic [REG_W-1:0]   ex_wdata,
  input  logic [REG_W-1:0]   ex_hi,
  input  logic [REG_W-1:0]   ex_lo,
  input  logic               ex_whilo,
  input  logic [ALUOP_W-1:0] ex_aluop,
  input  logic [REG_W-1:0]   ex_mem_addr,
  input  logic [REG_W-1:0]   ex_reg2,
  input  logic [2*REG_W-1:0] hilo_i,
  input  logic [1:0]         cnt_i,
  output logic [RADDR_W-1:0] mem_wd,
  output logic               mem_wreg,
  output logic [REG_W-1:0]   mem_wdata,
  output logic [REG_W-1:0]   mem_hi,
  output logic [REG_W-1:0]   mem_lo,
  output logic               mem_whilo,
  output logic [ALUOP_W-1:0] mem_aluop,
  output logic [REG_W-1:0]   mem_mem_addr,
  output logic [REG_W-1:0]   mem_reg2,
  output logic [2*REG_W-1:0] hilo_o,
  output logic [1:0]         cnt_o
);

  localparam int BUS_W = RADDR_W + 1 + 3 * REG_W + 1 + ALUOP_W + 2 * REG_W;

  // Single definition of the NOP/no-write contents used by reset, flush and bubbles.
  localparam logic [BUS_W-1:0] BUS_CLR = {
    RADDR_W'(NOP_REG_ADDR), WRITE_DISABLE, REG_W'(ZERO_WORD), REG_W'(ZERO_WORD),
    REG_W'(ZERO_WORD), WRITE_DISABLE, ALUOP_W'(EXE_NOP_OP), REG_W'(ZERO_WORD),
    REG_W'(ZERO_WORD)
  };

  logic [BUS_W-1:0] ex_bus;
  logic [BUS_W-1:0] mem_bus;
  logic             stall_ex;
  logic             stall_mem;
  logic             illegal_stall;
  logic             unused_stall;

  assign ex_bus = {ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop,
                   ex_mem_addr, ex_reg2};
  assign {mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
          mem_mem_addr, mem_reg2} = mem_bus;

  assign stall_ex      = stall[STALL_EX];
  assign stall_mem     = stall[STALL_MEM];
  assign illegal_stall = !stall_ex && stall_mem;
  assign unused_stall  = ^{stall[STALL_W-1:STALL_MEM+1], stall[STALL_EX-1:0]};

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      mem_bus <= BUS_CLR;
      hilo_o  <= '0;
      cnt_o   <= '0;
    end else if (stall_ex && !stall_mem) begin
      mem_bus <= BUS_CLR;
      hilo_o  <= hilo_i;
      cnt_o   <= cnt_i;
    end else if (!stall_ex) begin
      // Also covers the illegal MEM-only stall: the register still advances.
      mem_bus <= ex_bus;
      hilo_o  <= '0;
      cnt_o   <= '0;
    end else begin
      hilo_o  <= hilo_i;
      cnt_o   <= cnt_i;
    end
  end

  // ctrl only stalls contiguous low stages, so MEM stalled with EX running is a ctrl bug.
  always @(posedge clk) begin
    if (rst != RST_ENABLE)
      assert (!illegal_stall) else $warning("ex_mem_reg: MEM stalled while EX advances");
  end

endmodule

// File: tb/tb_ex_mem_reg.sv
// Scoreboard bench for ex_mem_reg: a reference model pushes the expected register
// contents each cycle; each scenario task pops and compares after the edge.
module tb_ex_mem_reg;
  import ex_mem_reg_pkg::*;

  typedef struct packed {
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        whilo;
    logic [7:0]  aluop;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [63:0] hilo;
    logic [1:0]  cnt;
  } out_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [4:0]  ex_wd;
  logic        ex_wreg;
  logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
  logic        ex_whilo;
  logic [7:0]  ex_aluop;
  logic [63:0] hilo_i;
  logic [1:0]  cnt_i;
  logic [4:0]  mem_wd;
  logic        mem_wreg;
  logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
  logic        mem_whilo;
  logic [7:0]  mem_aluop;
  logic [63:0] hilo_o;
  logic [1:0]  cnt_o;

  out_t model;
  out_t exp;
  out_t held;
  out_t sb[$];
  int   checks = 0;
  int   errors = 0;

  ex_mem_reg dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_hi(ex_hi), .ex_lo(ex_lo),
    .ex_whilo(ex_whilo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr), .ex_reg2(ex_reg2),
    .hilo_i(hilo_i), .cnt_i(cnt_i),
    .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_hi(mem_hi),
    .mem_lo(mem_lo), .mem_whilo(mem_whilo), .mem_aluop(mem_aluop),
    .mem_mem_addr(mem_mem_addr), .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
  );

  always #5 clk = ~clk;

  function automatic out_t sample();
    return '{mem_wd, mem_wreg, mem_wdata, mem_hi, mem_lo, mem_whilo, mem_aluop,
             mem_mem_addr, mem_reg2, hilo_o, cnt_o};
  endfunction

  // Reference behaviour, evaluated with the inputs present at the coming edge.
  function automatic out_t next_state(out_t cur);
    out_t n;
    n = cur;
    if (rst || flush) begin
      n = '0;
    end else if (stall[3] && !stall[4]) begin
      n = '0;
      n.hilo = hilo_i;
      n.cnt  = cnt_i;
    end else if (!stall[3]) begin
      n = '{ex_wd, ex_wreg, ex_wdata, ex_hi, ex_lo, ex_whilo, ex_aluop, ex_mem_addr,
            ex_reg2, 64'h0, 2'b00};
    end else begin
      n.hilo = hilo_i;
      n.cnt  = cnt_i;
    end
    return n;
  endfunction

  task automatic tick();
    model = next_state(model);
    sb.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic rand_ex();
    ex_wd       = 5'($urandom);
    ex_wreg     = 1'($urandom);
    ex_wdata    = $urandom;
    ex_hi       = $urandom;
    ex_lo       = $urandom;
    ex_whilo    = 1'($urandom);
    ex_aluop    = 8'($urandom);
    ex_mem_addr = $urandom;
    ex_reg2     = $urandom;
    hilo_i      = {$urandom, $urandom};
    cnt_i       = 2'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; stall = 6'h3f;
    ex_wd = '1; ex_wreg = 1'b1; ex_wdata = '1; ex_hi = '1; ex_lo = '1; ex_whilo = 1'b1;
    ex_aluop = '1; ex_mem_addr = '1; ex_reg2 = '1; hilo_i = '1; cnt_i = '1;
    model = '1;
    for (int i = 0; i < 2; i++) begin
      tick();
      exp = sb.pop_front();
      checks++;
      if (sample() !== exp || sample() !== out_t'(0)) begin
        errors++;
        $display("FAIL reset[%0d] got %h exp %h", i, sample(), exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_pass();
    stall = 6'b0;
    rand_ex();
    ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
    tick();
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp) begin
      errors++;
      $display("FAIL pass got %h exp %h", sample(), exp);
    end
    checks++;
    if (mem_wd !== 5'd3 || mem_wreg !== 1'b1 || mem_wdata !== 32'h1234_5678 || hilo_o !== 64'h0) begin
      errors++;
      $display("FAIL pass_fields wd %h wreg %b wdata %h hilo %h exp 03 1 12345678 0",
               mem_wd, mem_wreg, mem_wdata, hilo_o);
    end
  endtask

  task automatic test_bubble();
    stall = 6'b0;
    rand_ex();
    ex_aluop = EXE_LW_OP; ex_mem_addr = 32'h100;
    tick();
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || mem_aluop !== EXE_LW_OP || mem_mem_addr !== 32'h100) begin
      errors++;
      $display("FAIL load got %h exp %h", sample(), exp);
    end
    stall = 6'b001111;
    hilo_i = 64'hDEAD_BEEF_0BAD_F00D; cnt_i = 2'd1;
    tick();
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || mem_aluop !== 8'h0 || mem_wreg !== 1'b0 || hilo_o !== 64'hDEAD_BEEF_0BAD_F00D) begin
      errors++;
      $display("FAIL bubble got %h exp %h", sample(), exp);
    end
  endtask

  task automatic test_hold();
    stall = 6'b0;
    rand_ex();
    tick();
    exp = sb.pop_front();
    held = sample();
    checks++;
    if (sample() !== exp) begin
      errors++;
      $display("FAIL hold_load got %h exp %h", sample(), exp);
    end
    stall = 6'b011111;
    for (int i = 0; i < 3; i++) begin
      rand_ex();
      tick();
      exp = sb.pop_front();
      checks++;
      if (sample() !== exp || mem_wdata !== held.wdata || mem_mem_addr !== held.addr) begin
        errors++;
        $display("FAIL hold[%0d] got %h exp %h", i, sample(), exp);
      end
    end
    stall = 6'b0;
    ex_wdata = ~held.wdata;
    tick();
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || mem_wdata !== ~held.wdata) begin
      errors++;
      $display("FAIL hold_release got %h exp %h", sample(), exp);
    end
  endtask

  task automatic test_madd();
    stall = 6'b001111; hilo_i = 64'hA; cnt_i = 2'd1;
    tick();
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || hilo_o !== 64'hA || cnt_o !== 2'd1) begin
      errors++;
      $display("FAIL madd_c1 hilo %h cnt %0d exp hilo %h cnt %0d", hilo_o, cnt_o, exp.hilo, exp.cnt);
    end
    stall = 6'b0; hilo_i = 64'h55; cnt_i = 2'd2;
    tick();
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || hilo_o !== 64'h0 || cnt_o !== 2'd0) begin
      errors++;
      $display("FAIL madd_c2 hilo %h cnt %0d exp hilo %h cnt %0d", hilo_o, cnt_o, exp.hilo, exp.cnt);
    end
    stall = 6'b001111; hilo_i = 64'h1234; cnt_i = 2'd1;
    tick();
    void'(sb.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || cnt_o !== 2'd0 || hilo_o !== 64'h0) begin
      errors++;
      $display("FAIL madd_reset hilo %h cnt %0d exp 0 0", hilo_o, cnt_o);
    end
  endtask

  task automatic test_flush();
    stall = 6'b0;
    rand_ex();
    ex_wreg = 1'b1;
    tick();
    void'(sb.pop_front());
    stall = 6'b011111; flush = 1'b1; cnt_i = 2'd3; hilo_i = 64'hFFFF;
    tick();
    flush = 1'b0;
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || sample() !== out_t'(0)) begin
      errors++;
      $display("FAIL flush got %h exp %h", sample(), exp);
    end
  endtask

  task automatic test_illegal();
    stall = 6'b010000;
    rand_ex();
    #1;
    checks++;
    if (dut.illegal_stall !== 1'b1) begin
      errors++;
      $display("FAIL illegal_flag got %b exp 1", dut.illegal_stall);
    end
    tick();
    exp = sb.pop_front();
    checks++;
    if (sample() !== exp || mem_wdata !== ex_wdata) begin
      errors++;
      $display("FAIL illegal_advance got %h exp %h", sample(), exp);
    end
    stall = 6'b0;
    #1;
    checks++;
    if (dut.illegal_stall !== 1'b0) begin
      errors++;
      $display("FAIL legal_flag got %b exp 0", dut.illegal_stall);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] pats [4];
    pats[0] = 6'b000000; pats[1] = 6'b001111; pats[2] = 6'b011111; pats[3] = 6'b111111;
    for (int i = 0; i < 24; i++) begin
      rand_ex();
      stall = pats[$urandom_range(0, 3)];
      flush = ($urandom_range(0, 7) == 0);
      tick();
      exp = sb.pop_front();
      checks++;
      if (sample() !== exp) begin
        errors++;
        $display("FAIL b2b[%0d] got %h exp %h", i, sample(), exp);
      end
    end
    flush = 1'b0; stall = 6'b0;
  endtask

  initial begin
    test_reset();
    test_pass();
    test_bubble();
    test_hold();
    test_madd();
    test_flush();
    test_illegal();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
